// File: rtl/fofb_seq_pkg.sv
// fofb_seq_pkg: shared state encoding, widths and helpers for the FOFB mode sequencers
package fofb_seq_pkg;

    localparam int MAX_LEN = 512;
    localparam int FP32_W  = 32;
    localparam int ADDR_W  = 9;
    localparam int LEN_W   = ADDR_W + 1;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } seq_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/vm_seq_rd_pipe.sv
// vm_seq_rd_pipe: aligns read valid/last with the 1-cycle RAM latency, then registers them with the read data
module vm_seq_rd_pipe
    import fofb_seq_pkg::*;
#(
    parameter int DATA_W = FP32_W
) (
    input  logic              sysClk,
    input  logic              sysRst_n,
    input  logic              rd_en,
    input  logic              rd_last,
    input  logic [DATA_W-1:0] rd_data,
    output logic              valid,
    output logic              last,
    output logic [DATA_W-1:0] data
);

    logic en_q;
    logic last_q;

    // first stage tracks the RAM access, second stage captures the returned word with its flags
    always_ff @(posedge sysClk) begin
        if (!sysRst_n) begin
            en_q   <= 1'b0;
            last_q <= 1'b0;
            valid  <= 1'b0;
            last   <= 1'b0;
            data   <= '0;
        end else begin
            en_q   <= rd_en;
            last_q <= rd_last;
            valid  <= en_q;
            last   <= last_q;
            if (en_q) data <= rd_data;
        end
    end

endmodule

// File: rtl/vm_cal_sequencer.sv
// vm_cal_sequencer: sequences one eigen-mode projection (Ut/pos reads -> mult streams -> wait for accumulator result)
module vm_cal_sequencer #(
    parameter int    MAX_LEN = fofb_seq_pkg::MAX_LEN,
    parameter int    TIMEOUT = 1023,
    parameter string DEBUG   = "false"
) (
    input  logic                              sysClk,
    input  logic                              sysRst_n,
    input  logic                              trig,
    input  logic                              enable,
    input  logic [fofb_seq_pkg::LEN_W-1:0]    vec_len,
    input  logic                              clr_status,
    output logic                              pos_rdEn,
    output logic [fofb_seq_pkg::ADDR_W-1:0]   pos_rdAddr,
    input  logic [fofb_seq_pkg::FP32_W-1:0]   pos_rdData,
    output logic                              ut_outValid,
    output logic [fofb_seq_pkg::ADDR_W-1:0]   ut_ramRdAddr,
    output logic [fofb_seq_pkg::FP32_W-1:0]   eigen_vec_in,
    output logic                              eigen_vec_tvalid,
    output logic                              s_ut_tvalid_t,
    output logic                              eigen_vec_tlast,
    input  logic                              eigen_update_trig,
    output logic                              busy,
    output logic                              done,
    output logic                              timeout_err,
    output logic                              len_err,
    output logic [fofb_seq_pkg::CNT_W-1:0]    overrun_cnt,
    output logic [fofb_seq_pkg::CNT_W-1:0]    calc_latency
);

    import fofb_seq_pkg::*;

    localparam int TO_W = $clog2(TIMEOUT + 1);

    (* mark_debug = DEBUG *) seq_state_t       state;
    (* mark_debug = DEBUG *) seq_state_t       nxt;
    (* mark_debug = DEBUG *) logic [ADDR_W-1:0] idx;
    (* mark_debug = DEBUG *) logic [LEN_W-1:0]  len_q;
    (* mark_debug = DEBUG *) logic [TO_W-1:0]   to_cnt;
    (* mark_debug = DEBUG *) logic [CNT_W-1:0]  lat_cnt;
    logic trig_d;
    logic rise;
    logic start;
    logic len_ok;
    logic last_issue;
    logic expired;
    logic rd_en;

    assign rise       = trig & ~trig_d;
    assign start      = (state == S_IDLE) & rise & enable;
    assign len_ok     = (vec_len != '0) && (vec_len <= LEN_W'(MAX_LEN));
    assign last_issue = (state == S_ISSUE) && ({1'b0, idx} == len_q - LEN_W'(1));
    assign expired    = (state == S_WAIT) && (to_cnt == TO_W'(TIMEOUT));

    // state register
    always_ff @(posedge sysClk) begin
        if (!sysRst_n) state <= S_IDLE;
        else           state <= nxt;
    end

    // next state and state-decoded outputs; a result in the timeout cycle still wins
    always_comb begin
        nxt   = state;
        rd_en = 1'b0;
        busy  = 1'b1;
        done  = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                nxt  = (start && len_ok) ? S_ISSUE : S_IDLE;
            end
            S_ISSUE: begin
                rd_en = 1'b1;
                nxt   = last_issue ? S_WAIT : S_ISSUE;
            end
            S_WAIT:  nxt = eigen_update_trig ? S_DONE : (expired ? S_IDLE : S_WAIT);
            S_DONE: begin
                done = 1'b1;
                nxt  = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    assign pos_rdEn     = rd_en;
    assign ut_outValid  = rd_en;
    assign pos_rdAddr   = rd_en ? idx : '0;
    assign ut_ramRdAddr = pos_rdAddr;

    // trig edge detect, element index, timeout and latency counters
    always_ff @(posedge sysClk) begin
        if (!sysRst_n) begin
            trig_d       <= 1'b0;
            idx          <= '0;
            len_q        <= '0;
            to_cnt       <= '0;
            lat_cnt      <= '0;
            calc_latency <= '0;
        end else begin
            trig_d <= trig;
            if (start) begin
                len_q <= vec_len;
                idx   <= '0;
            end else if (state == S_ISSUE && !last_issue) begin
                idx <= idx + ADDR_W'(1);
            end
            to_cnt  <= (state == S_WAIT) ? to_cnt + TO_W'(1) : '0;
            lat_cnt <= start ? '0 : sat_inc(lat_cnt);
            if (state == S_WAIT && eigen_update_trig) calc_latency <= sat_inc(lat_cnt);
        end
    end

    // sticky status; a new event in the clear cycle takes precedence over the clear
    always_ff @(posedge sysClk) begin
        if (!sysRst_n) begin
            len_err     <= 1'b0;
            timeout_err <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            len_err     <= (start && !len_ok) || (len_err && !clr_status);
            timeout_err <= (expired && !eigen_update_trig) || (timeout_err && !clr_status);
            overrun_cnt <= (rise && state != S_IDLE) ? sat_inc(overrun_cnt) :
                           clr_status ? '0 : overrun_cnt;
        end
    end

    vm_seq_rd_pipe #(.DATA_W(FP32_W)) u_rd_pipe (
        .sysClk   (sysClk),
        .sysRst_n (sysRst_n),
        .rd_en    (rd_en),
        .rd_last  (last_issue),
        .rd_data  (pos_rdData),
        .valid    (eigen_vec_tvalid),
        .last     (eigen_vec_tlast),
        .data     (eigen_vec_in)
    );

    assign s_ut_tvalid_t = eigen_vec_tvalid;

endmodule

// File: tb/tb_vm_cal_sequencer.sv
// tb_vm_cal_sequencer: scoreboard bench for the Vm eigen-mode calculation sequencer
module tb_vm_cal_sequencer;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          cyc;
    } beat_t;

    typedef struct {
        int cyc;
        int lat;
    } done_t;

    logic        sysClk = 1'b0;
    logic        sysRst_n;
    logic        trig;
    logic        enable;
    logic [9:0]  vec_len;
    logic        clr_status;
    logic        pos_rdEn;
    logic [8:0]  pos_rdAddr;
    logic [31:0] pos_rdData = '0;
    logic        ut_outValid;
    logic [8:0]  ut_ramRdAddr;
    logic [31:0] eigen_vec_in;
    logic        eigen_vec_tvalid;
    logic        s_ut_tvalid_t;
    logic        eigen_vec_tlast;
    logic        eigen_update_trig;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic        len_err;
    logic [15:0] overrun_cnt;
    logic [15:0] calc_latency;

    int    cyc = 0;
    int    n_chk = 0;
    int    n_fail = 0;
    int    addr_q[$];
    beat_t beat_q[$];
    done_t done_q[$];

    vm_cal_sequencer dut (
        .sysClk            (sysClk),
        .sysRst_n          (sysRst_n),
        .trig              (trig),
        .enable            (enable),
        .vec_len           (vec_len),
        .clr_status        (clr_status),
        .pos_rdEn          (pos_rdEn),
        .pos_rdAddr        (pos_rdAddr),
        .pos_rdData        (pos_rdData),
        .ut_outValid       (ut_outValid),
        .ut_ramRdAddr      (ut_ramRdAddr),
        .eigen_vec_in      (eigen_vec_in),
        .eigen_vec_tvalid  (eigen_vec_tvalid),
        .s_ut_tvalid_t     (s_ut_tvalid_t),
        .eigen_vec_tlast   (eigen_vec_tlast),
        .eigen_update_trig (eigen_update_trig),
        .busy              (busy),
        .done              (done),
        .timeout_err       (timeout_err),
        .len_err           (len_err),
        .overrun_cnt       (overrun_cnt),
        .calc_latency      (calc_latency)
    );

    always #5 sysClk = ~sysClk;

    always @(posedge sysClk) cyc <= cyc + 1;

    // position buffer: 1-cycle read latency, word = 1.0f with the address in the low mantissa bits
    always @(posedge sysClk) if (pos_rdEn) pos_rdData <= 32'h3F80_0000 | 32'(pos_rdAddr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge sysClk);
        #1;
    endtask

    // queue the expected reads and beats for a transaction started now
    task automatic expect_stream(input int n, input int len);
        for (int i = 0; i < len; i++) begin
            addr_q.push_back(i);
            beat_q.push_back('{data: 32'h3F80_0000 | 32'(i), last: (i == len - 1), cyc: n + 3 + i});
        end
    endtask

    // start a calculation; gap>=0 returns the result gap cycles after the last beat
    task automatic run_txn(input int len, input int gap, input bit ovr);
        int n;
        n = cyc;
        expect_stream(n, len);
        if (gap >= 0) done_q.push_back('{cyc: n + len + 3 + gap, lat: len + 2 + gap});
        vec_len = 10'(len);
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
        if (gap >= 0) begin
            while (cyc < n + len + 2 + gap) begin
                tick(1);
                trig = ovr && ((cyc - n) == 3 || (cyc - n) == 5 || (cyc - n) == 7);
            end
            chk("busy_in_wait", 32'(busy), 1);
            eigen_update_trig = 1'b1;
            tick(1);
            eigen_update_trig = 1'b0;
            tick(2);
        end
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        tick(1);
        clr_status = 1'b0;
    endtask

    // monitor: pops the scoreboard whenever the DUT presents a read, a beat or a done
    always @(negedge sysClk) begin
        int    a;
        beat_t b;
        done_t d;
        if (pos_rdEn) begin
            chk("ut_en", 32'(ut_outValid), 1);
            chk("ut_addr", 32'(ut_ramRdAddr), 32'(pos_rdAddr));
            if (addr_q.size() == 0) chk("rd_unexpected", 32'(pos_rdEn), 0);
            else begin
                a = addr_q.pop_front();
                chk("rd_addr", 32'(pos_rdAddr), a);
            end
        end
        if (eigen_vec_tvalid) begin
            chk("b_valid", 32'(s_ut_tvalid_t), 1);
            if (beat_q.size() == 0) chk("beat_unexpected", 32'(eigen_vec_tvalid), 0);
            else begin
                b = beat_q.pop_front();
                chk("beat_data", eigen_vec_in, b.data);
                chk("beat_last", 32'(eigen_vec_tlast), 32'(b.last));
                chk("beat_cycle", cyc, b.cyc);
            end
        end else if (eigen_vec_tlast || s_ut_tvalid_t) begin
            chk("idle_stream", {30'd0, eigen_vec_tlast, s_ut_tvalid_t}, 0);
        end
        if (done) begin
            if (done_q.size() == 0) chk("done_unexpected", 32'(done), 0);
            else begin
                d = done_q.pop_front();
                chk("done_cycle", cyc, d.cyc);
                chk("calc_latency", 32'(calc_latency), d.lat);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        sysRst_n = 1'b0;
        trig = 1'b0;
        enable = 1'b1;
        vec_len = '0;
        clr_status = 1'b0;
        eigen_update_trig = 1'b0;
        tick(3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rden", 32'(pos_rdEn), 0);
        chk("rst_tvalid", 32'(eigen_vec_tvalid), 0);
        chk("rst_data", eigen_vec_in, 0);
        chk("rst_errs", {30'd0, timeout_err, len_err}, 0);
        chk("rst_overrun", 32'(overrun_cnt), 0);
        chk("rst_latency", 32'(calc_latency), 0);
        sysRst_n = 1'b1;
        tick(2);

        run_txn(4, 20, 1'b0);
        chk("lat_len4", 32'(calc_latency), 26);
        chk("idle_after_done", 32'(busy), 0);

        vec_len = 10'd0;
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
        chk("len0_err", 32'(len_err), 1);
        chk("len0_busy", 32'(busy), 0);
        tick(3);
        pulse_clr();
        chk("len0_clr", 32'(len_err), 0);
        vec_len = 10'd600;
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
        chk("len600_err", 32'(len_err), 1);
        tick(3);
        pulse_clr();
        chk("len600_clr", 32'(len_err), 0);

        enable = 1'b0;
        vec_len = 10'd4;
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
        tick(2);
        chk("disabled_busy", 32'(busy), 0);
        enable = 1'b1;

        run_txn(512, 5, 1'b0);
        chk("lat_len512", 32'(calc_latency), 519);

        n = cyc;
        run_txn(3, -1, 1'b0);
        while (!timeout_err && cyc < n + 2000) tick(1);
        chk("timeout_cycle", cyc, n + 3 + 1025);
        chk("timeout_busy", 32'(busy), 0);
        run_txn(2, 0, 1'b0);
        chk("timeout_sticky", 32'(timeout_err), 1);
        pulse_clr();
        chk("timeout_clr", 32'(timeout_err), 0);

        chk("overrun_pre", 32'(overrun_cnt), 0);
        run_txn(16, 20, 1'b1);
        chk("overrun_cnt", 32'(overrun_cnt), 3);

        n = cyc;
        expect_stream(n, 64);
        vec_len = 10'd64;
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
        while (cyc < n + 12) tick(1);
        sysRst_n = 1'b0;
        tick(1);
        addr_q.delete();
        beat_q.delete();
        chk("midrst_rden", 32'(pos_rdEn), 0);
        chk("midrst_tvalid", 32'(eigen_vec_tvalid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_overrun", 32'(overrun_cnt), 0);
        chk("midrst_latency", 32'(calc_latency), 0);
        sysRst_n = 1'b1;
        tick(2);
        run_txn(4, 20, 1'b0);
        chk("post_rst_lat", 32'(calc_latency), 26);

        tick(5);
        chk("addr_left", addr_q.size(), 0);
        chk("beats_left", beat_q.size(), 0);
        chk("done_left", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
